stage_pipe_sched: RTL and testbench

Round-robin scheduler that shares one fixed-latency two-input bit datapath between two requesters. In the dut hierarchy this is the two-stage pipeline: stage 1 registers in1/in2, stage 2 ANDs them and registers out. The block grants one operand pair per cycle and tracks each issued operation through the pipeline. It returns each result, tagged with its requester id, through a credit-protected response FIFO so that response backpressure never drops a result.

---
 rtl/stage_pipe_sched.sv | 158 +++++++++++++++
 tb/tb_stage_pipe_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_pipe_sched.sv
// Round-robin issue of two requesters into a shared fixed-latency bit datapath;
// results return in issue order, tagged with requester id, through a credit-protected FIFO.
module stage_pipe_sched #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_a,
    input  logic [1:0] req_b,
    output logic [1:0] req_ready,
    output logic       pipe_in1,
    output logic       pipe_in2,
    input  logic       pipe_out,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_data,
    input  logic       rsp_ready
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic up, input logic dn);
        case ({up, dn})
            2'b10:   return c + CNT_W'(1);
            2'b01:   return c - CNT_W'(1);
            default: return c;
        endcase
    endfunction

    logic             prio;
    logic [CNT_W-1:0] out_cnt;
    logic             credit_ok;
    logic             issue_vld_p0;
    logic             grant_id_p0;

    logic             tag_vld_p [LATENCY];
    logic             tag_id_p  [LATENCY];
    logic             wr_vld;
    logic             wr_id;
    logic             wr_data;

    logic             mem_id   [DEPTH];
    logic             mem_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] fifo_cnt_nx;
    logic [CNT_W-1:0] fifo_remain;
    logic             head_vld_nx;
    logic             head_id_nx;
    logic             head_data_nx;
    logic             pop;

    // Stage p0: grant and datapath drive
    always_comb begin
        credit_ok   = rst_n && (out_cnt < DEPTH_C);
        req_ready   = 2'b00;
        grant_id_p0 = 1'b0;
        if (credit_ok) begin
            case (req_valid)
                2'b01: begin
                    req_ready   = 2'b01;
                    grant_id_p0 = 1'b0;
                end
                2'b10: begin
                    req_ready   = 2'b10;
                    grant_id_p0 = 1'b1;
                end
                2'b11: begin
                    req_ready   = prio ? 2'b10 : 2'b01;
                    grant_id_p0 = prio;
                end
                default: begin
                    req_ready   = 2'b00;
                    grant_id_p0 = 1'b0;
                end
            endcase
        end
        issue_vld_p0 = |req_ready;
        pipe_in1     = issue_vld_p0 & req_a[grant_id_p0];
        pipe_in2     = issue_vld_p0 & req_b[grant_id_p0];
    end

    // Stage p1..pLATENCY: tag tracking; the last slot lines up with pipe_out
    assign wr_vld  = tag_vld_p[LATENCY-1];
    assign wr_id   = tag_id_p[LATENCY-1];
    assign wr_data = pipe_out;
    assign pop     = rsp_valid & rsp_ready;

    // Response head is registered, so an entry written into an empty FIFO bypasses to the head
    always_comb begin
        fifo_cnt_nx  = cnt_step(fifo_cnt, wr_vld, pop);
        fifo_remain  = fifo_cnt - CNT_W'(pop);
        rd_ptr_nx    = pop ? ptr_inc(rd_ptr) : rd_ptr;
        head_vld_nx  = (fifo_cnt_nx != '0);
        head_id_nx   = 1'b0;
        head_data_nx = 1'b0;
        if (head_vld_nx) begin
            if (fifo_remain == '0) begin
                head_id_nx   = wr_id;
                head_data_nx = wr_data;
            end else begin
                head_id_nx   = mem_id[rd_ptr_nx];
                head_data_nx = mem_data[rd_ptr_nx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= 1'b0;
            out_cnt   <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 1'b0;
            for (int i = 0; i < LATENCY; i++) tag_vld_p[i] <= 1'b0;
        end else begin
            if (issue_vld_p0) prio <= ~grant_id_p0;
            out_cnt   <= cnt_step(out_cnt, issue_vld_p0, pop);
            fifo_cnt  <= fifo_cnt_nx;
            if (wr_vld) wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr    <= rd_ptr_nx;
            rsp_valid <= head_vld_nx;
            rsp_id    <= head_id_nx;
            rsp_data  <= head_data_nx;
            tag_vld_p[0] <= issue_vld_p0;
            for (int i = 1; i < LATENCY; i++) tag_vld_p[i] <= tag_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id_p[0] <= grant_id_p0;
        for (int i = 1; i < LATENCY; i++) tag_id_p[i] <= tag_id_p[i-1];
        if (wr_vld) begin
            mem_id[wr_ptr]   <= wr_id;
            mem_data[wr_ptr] <= wr_data;
        end
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        wr_vld |-> (fifo_cnt < DEPTH_C));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        out_cnt <= DEPTH_C);

endmodule

// File: tb/tb_stage_pipe_sched.sv
// Bench for stage_pipe_sched: four builds (latency/depth variants) each fed by an AND datapath model.
module tb_stage_pipe_sched;
    localparam int NK = 4;
    localparam int LAT_T [NK] = '{2, 1, 4, 2};
    localparam int DEP_T [NK] = '{4, 4, 4, 3};

    localparam bit OP_A [10] = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 1};
    localparam bit OP_B [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 0};
    localparam bit OP_R [10] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0};

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid [NK];
    logic [1:0] req_a     [NK];
    logic [1:0] req_b     [NK];
    logic [1:0] req_ready [NK];
    logic       pipe_in1  [NK];
    logic       pipe_in2  [NK];
    logic       pipe_out  [NK];
    logic       rsp_valid [NK];
    logic       rsp_id    [NK];
    logic       rsp_data  [NK];
    logic       rsp_ready [NK];

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        localparam int L = LAT_T[k];
        logic dp_d [L];
        logic dp_v [L];
        logic junk;

        stage_pipe_sched #(.LATENCY(L), .DEPTH(DEP_T[k])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[k]),
            .req_a     (req_a[k]),
            .req_b     (req_b[k]),
            .req_ready (req_ready[k]),
            .pipe_in1  (pipe_in1[k]),
            .pipe_in2  (pipe_in2[k]),
            .pipe_out  (pipe_out[k]),
            .rsp_valid (rsp_valid[k]),
            .rsp_id    (rsp_id[k]),
            .rsp_data  (rsp_data[k]),
            .rsp_ready (rsp_ready[k])
        );

        // AND datapath with L register stages; idle slots output a toggling junk bit
        always @(posedge clk) begin
            for (int i = L - 1; i > 0; i--) begin
                dp_d[i] <= dp_d[i-1];
                dp_v[i] <= dp_v[i-1];
            end
            dp_d[0] <= pipe_in1[k] & pipe_in2[k];
            dp_v[0] <= |(req_valid[k] & req_ready[k]);
            junk    <= ~junk;
        end
        assign pipe_out[k] = dp_v[L-1] ? dp_d[L-1] : junk;
    end

    typedef struct {
        logic [1:0] vld, a, b;
        logic       rr;
        logic [1:0] rdy;
        logic       i1, i2, rv, rid, rd;
    } vec_t;
    vec_t tq[$];

    task automatic check(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, got, want);
    endtask

    task automatic add(input logic [1:0] v, input logic [1:0] a, input logic [1:0] b,
                       input logic rr, input logic [1:0] rdy, input logic i1, input logic i2,
                       input logic rv, input logic rid, input logic rd);
        vec_t t;
        t.vld = v; t.a = a; t.b = b; t.rr = rr; t.rdy = rdy;
        t.i1 = i1; t.i2 = i2; t.rv = rv; t.rid = rid; t.rd = rd;
        tq.push_back(t);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues ten ops on build k, alternating requester, with gaps and response backpressure
    task automatic run_ops(input int k, input int gap_mod, input int stall_until);
        int iss = 0, pops = 0, cyc = 0, first_iss = -1, first_rsp = -1;
        int outst;
        int d = DEP_T[k];
        int l = LAT_T[k];
        logic present;
        logic [1:0] onehot, want_rdy;
        while ((iss < 10 || pops < 10) && cyc < 400) begin
            present = (iss < 10) && ((cyc % gap_mod) != (gap_mod - 1));
            onehot  = 2'b01 << (iss % 2);
            req_valid[k] = present ? onehot : 2'b00;
            req_a[k]     = (present && OP_A[iss]) ? onehot : 2'b00;
            req_b[k]     = (present && OP_B[iss]) ? onehot : 2'b00;
            rsp_ready[k] = (cyc >= stall_until) && ((cyc % 3) != 2);
            @(negedge clk);
            outst    = iss - pops;
            want_rdy = (present && outst < d) ? onehot : 2'b00;
            check($sformatf("b%0d.c%0d.req_ready", k, cyc), req_ready[k], want_rdy);
            if (rsp_valid[k]) begin
                if (first_rsp < 0) first_rsp = cyc;
                if (pops < 10) begin
                    check($sformatf("b%0d.rsp%0d.id", k, pops), rsp_id[k], pops % 2);
                    check($sformatf("b%0d.rsp%0d.data", k, pops), rsp_data[k], OP_R[pops]);
                    if (rsp_ready[k]) pops++;
                end else begin
                    check($sformatf("b%0d.extra_rsp", k), rsp_valid[k], 0);
                end
            end
            if (present && req_ready[k] != 2'b00) begin
                if (first_iss < 0) first_iss = cyc;
                iss++;
            end
            cyc++;
            next_cycle();
        end
        req_valid[k] = 2'b00;
        rsp_ready[k] = 1'b1;
        check($sformatf("b%0d.issued", k), iss, 10);
        check($sformatf("b%0d.popped", k), pops, 10);
        check($sformatf("b%0d.latency", k), first_rsp - first_iss, l + 1);
        repeat (3) begin
            @(negedge clk);
            check($sformatf("b%0d.idle_rsp_valid", k), rsp_valid[k], 0);
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        for (int k = 0; k < NK; k++) begin
            req_valid[k] = 2'b00; req_a[k] = 2'b00; req_b[k] = 2'b00; rsp_ready[k] = 1'b1;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            check($sformatf("b%0d.rst.req_ready", k), req_ready[k], 0);
            check($sformatf("b%0d.rst.pipe_in1", k), pipe_in1[k], 0);
            check($sformatf("b%0d.rst.pipe_in2", k), pipe_in2[k], 0);
            check($sformatf("b%0d.rst.rsp_valid", k), rsp_valid[k], 0);
            check($sformatf("b%0d.rst.rsp_id", k), rsp_id[k], 0);
            check($sformatf("b%0d.rst.rsp_data", k), rsp_data[k], 0);
        end
        next_cycle();
        rst_n = 1'b1;

        // single requester 1, back-to-back
        add(2'b10, 2'b10, 2'b10, 1, 2'b10, 1, 1, 0, 0, 0);
        add(2'b10, 2'b10, 2'b00, 1, 2'b10, 1, 0, 0, 0, 0);
        add(2'b10, 2'b00, 2'b10, 1, 2'b10, 0, 1, 0, 0, 0);
        add(2'b10, 2'b10, 2'b10, 1, 2'b10, 1, 1, 1, 1, 1);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 1, 0);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 1, 0);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 1, 1);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
        // contention: requester 0 gives 1, requester 1 gives 0
        add(2'b11, 2'b11, 2'b01, 1, 2'b01, 1, 1, 0, 0, 0);
        add(2'b11, 2'b11, 2'b01, 1, 2'b10, 1, 0, 0, 0, 0);
        add(2'b11, 2'b11, 2'b01, 1, 2'b01, 1, 1, 0, 0, 0);
        add(2'b11, 2'b11, 2'b01, 1, 2'b10, 1, 0, 1, 0, 1);
        add(2'b11, 2'b11, 2'b01, 1, 2'b01, 1, 1, 1, 1, 0);
        add(2'b11, 2'b11, 2'b01, 1, 2'b10, 1, 0, 1, 0, 1);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 1, 0);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 0, 1);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 1, 0);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
        // backpressure: requester 0 gives 0, requester 1 gives 1
        add(2'b11, 2'b11, 2'b10, 0, 2'b01, 1, 0, 0, 0, 0);
        add(2'b11, 2'b11, 2'b10, 0, 2'b10, 1, 1, 0, 0, 0);
        add(2'b11, 2'b11, 2'b10, 0, 2'b01, 1, 0, 0, 0, 0);
        add(2'b11, 2'b11, 2'b10, 0, 2'b10, 1, 1, 1, 0, 0);
        add(2'b11, 2'b11, 2'b10, 0, 2'b00, 0, 0, 1, 0, 0);
        add(2'b11, 2'b11, 2'b10, 0, 2'b00, 0, 0, 1, 0, 0);
        add(2'b11, 2'b11, 2'b10, 1, 2'b00, 0, 0, 1, 0, 0);
        add(2'b11, 2'b11, 2'b10, 0, 2'b01, 1, 0, 1, 1, 1);
        add(2'b11, 2'b11, 2'b10, 0, 2'b00, 0, 0, 1, 1, 1);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 1, 1);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 0, 0);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 1, 1);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 0, 0);
        add(2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);

        for (int i = 0; i < tq.size(); i++) begin
            req_valid[0] = tq[i].vld;
            req_a[0]     = tq[i].a;
            req_b[0]     = tq[i].b;
            rsp_ready[0] = tq[i].rr;
            @(negedge clk);
            check($sformatf("v%0d.req_ready", i), req_ready[0], tq[i].rdy);
            check($sformatf("v%0d.pipe_in1", i), pipe_in1[0], tq[i].i1);
            check($sformatf("v%0d.pipe_in2", i), pipe_in2[0], tq[i].i2);
            check($sformatf("v%0d.rsp_valid", i), rsp_valid[0], tq[i].rv);
            if (tq[i].rv) begin
                check($sformatf("v%0d.rsp_id", i), rsp_id[0], tq[i].rid);
                check($sformatf("v%0d.rsp_data", i), rsp_data[0], tq[i].rd);
            end
            next_cycle();
        end

        // reset while two ops from requester 0 are in flight (priority then points at 1)
        for (int i = 0; i < 2; i++) begin
            req_valid[0] = 2'b01; req_a[0] = 2'b01; req_b[0] = 2'b01; rsp_ready[0] = 1'b1;
            @(negedge clk);
            check($sformatf("mid.issue%0d.req_ready", i), req_ready[0], 2'b01);
            next_cycle();
        end
        rst_n = 1'b0;
        req_valid[0] = 2'b11; req_a[0] = 2'b11; req_b[0] = 2'b11;
        @(negedge clk);
        check("mid.rst.req_ready", req_ready[0], 0);
        check("mid.rst.pipe_in1", pipe_in1[0], 0);
        check("mid.rst.pipe_in2", pipe_in2[0], 0);
        check("mid.rst.rsp_valid", rsp_valid[0], 0);
        check("mid.rst.rsp_id", rsp_id[0], 0);
        check("mid.rst.rsp_data", rsp_data[0], 0);
        next_cycle();
        rst_n = 1'b1;
        req_valid[0] = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("mid.after%0d.rsp_valid", i), rsp_valid[0], 0);
            next_cycle();
        end
        req_valid[0] = 2'b11;
        @(negedge clk);
        check("mid.rearb.req_ready", req_ready[0], 2'b01);
        check("mid.rearb.pipe_in1", pipe_in1[0], 1);
        next_cycle();
        req_valid[0] = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("mid.rsp%0d.rsp_valid", i), rsp_valid[0], (i == 3) ? 1 : 0);
            if (i == 3) begin
                check("mid.rsp.rsp_id", rsp_id[0], 0);
                check("mid.rsp.rsp_data", rsp_data[0], 1);
            end
            next_cycle();
        end

        run_ops(1, 4, 0);
        run_ops(2, 3, 0);
        run_ops(3, 100, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
